// File: rtl/param_regfile_if.sv
// param_regfile_if: register-file bus bundle.
// Ports: we/waddr/wdata write request, raddr_a/raddr_b read addresses,
//        rdata_a/rdata_b registered read data, clr_req/clr_busy/clr_done clear handshake.
interface param_regfile_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;
    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr_req,
        input  rdata_a, rdata_b, clr_busy, clr_done
    );
    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
        output rdata_a, rdata_b, clr_busy, clr_done
    );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: two-read one-write register file with registered reads and sequential clear.
// Ports: clk_i clock, rst_ni async active-low reset, bus slave side of param_regfile_if.
module param_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            clk_i,
    input logic            rst_ni,
    param_regfile_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_b_q, rdata_a_d, rdata_b_d;
    logic             wr_ok;
    // Out-of-range addresses and the hardwired zero register are not backed by storage.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction
    assign wr_ok = bus.we && state_q != CLEAR && addr_ok(bus.waddr);
    // Forwarding only uses accepted writes, so writes dropped during a clear never leak out.
    always_comb begin
        rdata_a_d = !addr_ok(bus.raddr_a) ? '0 :
                    (BYPASS != 0 && wr_ok && bus.waddr == bus.raddr_a) ? bus.wdata : mem_q[bus.raddr_a];
        rdata_b_d = !addr_ok(bus.raddr_b) ? '0 :
                    (BYPASS != 0 && wr_ok && bus.waddr == bus.raddr_b) ? bus.wdata : mem_q[bus.raddr_b];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.clr_req) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (state_q == CLEAR) mem_q[idx_q] <= '0;
            else if (wr_ok) mem_q[bus.waddr] <= bus.wdata;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed checks of param_regfile (default, no-bypass and 8x5 variants).
module tb_param_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;

    param_regfile_if #(.WIDTH(32), .DEPTH(32)) m_if ();
    param_regfile_if #(.WIDTH(32), .DEPTH(32)) nb_if ();
    param_regfile_if #(.WIDTH(8),  .DEPTH(5))  s_if ();

    param_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(m_if));
    param_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (.clk_i(clk), .rst_ni(rst_n), .bus(nb_if));
    param_regfile #(.WIDTH(8),  .DEPTH(5),  .ZERO_REG(1), .BYPASS(1)) dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(s_if));

    assign nb_if.we      = m_if.we;
    assign nb_if.waddr   = m_if.waddr;
    assign nb_if.wdata   = m_if.wdata;
    assign nb_if.raddr_a = m_if.raddr_a;
    assign nb_if.raddr_b = m_if.raddr_b;
    assign nb_if.clr_req = m_if.clr_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int dn;
        m_if.we = 0; m_if.waddr = '0; m_if.wdata = '0;
        m_if.raddr_a = '0; m_if.raddr_b = '0; m_if.clr_req = 0;
        s_if.we = 0; s_if.waddr = '0; s_if.wdata = '0;
        s_if.raddr_a = '0; s_if.raddr_b = '0; s_if.clr_req = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdata_a", m_if.rdata_a, 0);
        check("rst_rdata_b", m_if.rdata_b, 0);
        check("rst_busy", 32'(m_if.clr_busy), 0);
        check("rst_done", 32'(m_if.clr_done), 0);
        tick; tick;
        rst_n = 1'b1;
        // every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            m_if.raddr_a = 5'(a); m_if.raddr_b = 5'(31 - a);
            tick;
            check($sformatf("rst_rd_a%0d", a), m_if.rdata_a, 0);
            check($sformatf("rst_rd_b%0d", 31 - a), m_if.rdata_b, 0);
        end
        // same-edge write/read: forwarded vs old content
        m_if.we = 1; m_if.waddr = 5; m_if.wdata = 32'hDEADBEEF; m_if.raddr_a = 5; m_if.raddr_b = 5;
        tick;
        check("byp_a", m_if.rdata_a, 32'hDEADBEEF);
        check("byp_b", m_if.rdata_b, 32'hDEADBEEF);
        check("nobyp_a", nb_if.rdata_a, 0);
        m_if.we = 0;
        tick;
        check("after_byp_a", m_if.rdata_a, 32'hDEADBEEF);
        check("after_nobyp_a", nb_if.rdata_a, 32'hDEADBEEF);
        // register 0 is hardwired
        m_if.we = 1; m_if.waddr = 0; m_if.wdata = 32'h12345678; m_if.raddr_a = 0;
        tick;
        check("zero_byp", m_if.rdata_a, 0);
        m_if.we = 0;
        tick;
        check("zero_rd", m_if.rdata_a, 0);
        // fill and read back
        for (int a = 0; a < 32; a++) begin
            m_if.we = 1; m_if.waddr = 5'(a); m_if.wdata = 32'(a + 1);
            tick;
        end
        m_if.we = 0;
        for (int a = 0; a < 32; a++) begin
            m_if.raddr_a = 5'(a); m_if.raddr_b = 5'(a);
            tick;
            check($sformatf("fill_a%0d", a), m_if.rdata_a, a == 0 ? 0 : 32'(a + 1));
            check($sformatf("fill_b%0d", a), m_if.rdata_b, a == 0 ? 0 : 32'(a + 1));
        end
        // clear request with a simultaneous write that must land (then get cleared)
        m_if.clr_req = 1; m_if.we = 1; m_if.waddr = 9; m_if.wdata = 32'h99; m_if.raddr_a = 9;
        tick;
        check("clr_same_edge_wr", m_if.rdata_a, 32'h99);
        check("clr_busy_start", 32'(m_if.clr_busy), 1);
        m_if.clr_req = 0; m_if.we = 0;
        cnt = 1; dn = 0;
        for (int i = 0; i < 40 && m_if.clr_busy; i++) begin
            m_if.clr_req = (i == 5);
            m_if.we = (i == 19); m_if.waddr = 3; m_if.wdata = 32'hBAD; m_if.raddr_a = 3;
            tick;
            if (m_if.clr_busy) cnt++;
            if (m_if.clr_busy && m_if.clr_done) dn++;
            if (i == 19) check("busy_wr_no_fwd", m_if.rdata_a, 0);
        end
        m_if.clr_req = 0;
        check("clr_cycles", 32'(cnt), 32);
        check("done_while_busy", 32'(dn), 0);
        check("done_pulse", 32'(m_if.clr_done), 1);
        // in DONE: clr_req ignored, write accepted
        m_if.clr_req = 1; m_if.we = 1; m_if.waddr = 12; m_if.wdata = 32'hC0FFEE;
        tick;
        check("done_low", 32'(m_if.clr_done), 0);
        check("no_restart", 32'(m_if.clr_busy), 0);
        m_if.clr_req = 0; m_if.we = 0;
        tick;
        check("idle_busy", 32'(m_if.clr_busy), 0);
        for (int a = 0; a < 32; a++) begin
            m_if.raddr_a = 5'(a); m_if.raddr_b = 5'(a);
            tick;
            check($sformatf("clr_a%0d", a), m_if.rdata_a, a == 12 ? 32'hC0FFEE : 0);
            check($sformatf("clr_b%0d", a), m_if.rdata_b, a == 12 ? 32'hC0FFEE : 0);
        end
        // reset in the middle of a clear
        for (int a = 1; a < 32; a++) begin
            m_if.we = 1; m_if.waddr = 5'(a); m_if.wdata = 32'(a + 1);
            tick;
        end
        m_if.we = 0; m_if.raddr_a = 20; m_if.clr_req = 1;
        tick;
        m_if.clr_req = 0;
        for (int i = 0; i < 9; i++) tick;
        check("pre_rst_busy", 32'(m_if.clr_busy), 1);
        check("pre_rst_rd20", m_if.rdata_a, 32'd21);
        rst_n = 1'b0;
        #1;
        check("async_rd_a", m_if.rdata_a, 0);
        check("async_rd_b", m_if.rdata_b, 0);
        check("async_busy", 32'(m_if.clr_busy), 0);
        check("async_done", 32'(m_if.clr_done), 0);
        tick;
        rst_n = 1'b1;
        m_if.we = 1; m_if.waddr = 7; m_if.wdata = 32'hA5A5A5A5; m_if.raddr_a = 25;
        tick;
        check("post_rst_rd25", m_if.rdata_a, 0);
        m_if.we = 0; m_if.raddr_a = 7;
        tick;
        check("post_rst_rd7", m_if.rdata_a, 32'hA5A5A5A5);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            dn += m_if.clr_done ? 1 : 0;
            dn += m_if.clr_busy ? 1 : 0;
        end
        check("aborted_no_done", 32'(dn), 0);
        // 8-bit x 5 variant
        s_if.we = 1; s_if.waddr = 3'd6; s_if.wdata = 8'h3C; s_if.raddr_a = 3'd6;
        tick;
        check("s_oob_byp", 32'(s_if.rdata_a), 0);
        s_if.waddr = 3'd4; s_if.wdata = 8'h44;
        tick;
        s_if.we = 0; s_if.raddr_a = 3'd6; s_if.raddr_b = 3'd4;
        tick;
        check("s_oob_rd", 32'(s_if.rdata_a), 0);
        check("s_rd4", 32'(s_if.rdata_b), 32'h44);
        s_if.clr_req = 1;
        tick;
        s_if.clr_req = 0;
        cnt = s_if.clr_busy ? 1 : 0;
        for (int i = 0; i < 20 && s_if.clr_busy; i++) begin
            tick;
            if (s_if.clr_busy) cnt++;
        end
        check("s_clr_cycles", 32'(cnt), 5);
        check("s_done", 32'(s_if.clr_done), 1);
        tick;
        check("s_rd4_cleared", 32'(s_if.rdata_b), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (>=2); AW = ceil(log2(DEPTH)).
REQ-003 SHALL have parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enabled when 1.
REQ-005 SHALL have port: clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: we  input  1  write enable.
REQ-008 SHALL have port: waddr  input  AW  write address.
REQ-009 SHALL have port: wdata  input  WIDTH  write data.
REQ-010 SHALL have port: raddr_a  input  AW  read address, port A.
REQ-011 SHALL have port: raddr_b  input  AW  read address, port B.
REQ-012 SHALL have port: rdata_a  output  WIDTH  registered read data, port A.
REQ-013 SHALL have port: rdata_b  output  WIDTH  registered read data, port B.
REQ-014 SHALL have port: clr_req  input  1  request a sequential clear of all registers.
REQ-015 SHALL have port: clr_busy  output  1  high while the clear sequence runs.
REQ-016 SHALL have port: clr_done  output  1  one-cycle pulse when the clear completes.

Function
REQ-017 Write: on rising edge with we=1, clr_busy=0, waddr<DEPTH, SHALL store wdata at waddr.
REQ-018 Writes to waddr>=DEPTH SHALL be ignored; with ZERO_REG=1, writes to address 0 SHALL be ignored.
REQ-019 Read latency SHALL be exactly 1 cycle: rdata_x after edge N = content of raddr_x sampled at edge N.
REQ-020 raddr_x>=DEPTH, or raddr_x=0 with ZERO_REG=1, SHALL return all zeros.
REQ-021 BYPASS=1: if a write accepted at edge N targets raddr_x, rdata_x after edge N SHALL equal wdata; BYPASS=0: it SHALL equal the old content.
REQ-022 Both ports SHALL read the same address independently with identical results.
REQ-023 Clear FSM states: IDLE, CLEAR, DONE; SHALL reset to IDLE.
REQ-024 IDLE -> CLEAR on edge with clr_req=1; index counter loaded to 0; clr_busy=1 from the following cycle.
REQ-025 CLEAR: SHALL zero register[index] each cycle, index+1; after index DEPTH-1 is zeroed -> DONE (exactly DEPTH cycles in CLEAR).
REQ-026 DONE: clr_done=1, clr_busy=0 for exactly one cycle, then -> IDLE unconditionally.
REQ-027 clr_req SHALL be ignored in CLEAR and DONE (no restart, no queueing).
REQ-028 Write and clr_req on the same IDLE edge: the write SHALL take effect; clear starts next cycle and overwrites it.
REQ-029 Writes during CLEAR SHALL be ignored; reads during CLEAR SHALL return current contents (partially cleared); bypass SHALL not forward ignored writes.
REQ-030 Write accepted in DONE SHALL take effect normally.

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) zero all registers, rdata_a, rdata_b, clr_busy, clr_done, index, and force FSM to IDLE.
REQ-032 Reset asserted mid-CLEAR SHALL abort the clear; no clr_done pulse SHALL occur.
REQ-033 After reset deasserts, the first write SHALL be accepted on the next rising edge.

Verification
REQ-034 Reset then read all addresses on both ports -> every rdata = 0x00000000 one cycle after each address.
REQ-035 Write 0xDEADBEEF to addr 5, raddr_a=5 same edge -> rdata_a=0xDEADBEEF next cycle (BYPASS=1), 0x00000000 (BYPASS=0); next read 0xDEADBEEF.
REQ-036 Write 0x12345678 to addr 0 (ZERO_REG=1) -> read addr 0 = 0x00000000.
REQ-037 Fill all 32 regs with addr+1, pulse clr_req -> clr_busy high 32 cycles, one clr_done pulse, all reads 0; write during busy to addr 3 ignored.
REQ-038 Assert reset at 10th CLEAR cycle -> all outputs 0 immediately, FSM IDLE, no clr_done; subsequent write/read of addr 7 = 0xA5A5A5A5 works.
REQ-039 Parameter sweep WIDTH=8, DEPTH=5 -> write to addr 6 ignored, read addr 6 = 0x00, clear lasts 5 cycles.
